// File: rtl/sdram_tester_pkg.sv
// Shared definitions for the SDRAM burst tester: FSM state encodings,
// default interface widths and the LFSR pattern step function.
package sdram_tester_pkg;

    localparam int DEF_DATA_BITS  = 16;
    localparam int DEF_ADDR_BITS  = 24;
    localparam int DEF_BURST_BITS = 10;

    // Right-shift Galois taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_WAIT = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } tester_state_t;

    // One Galois LFSR step: shift right, fold the taps in when a one falls out
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_POLY;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// Deterministic data pattern source, used both to produce write data and
// to predict read data. Default build yields seed + n; with the macro
// SDRAM_TESTER_LFSR_EN defined it yields a 16-bit Galois LFSR sequence
// (seed 0 promoted to 1, value replicated across wider words).
module sdram_pattern_gen
    import sdram_tester_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] seed,
    input  logic                 step,
    output logic [DATA_BITS-1:0] value
);

`ifdef SDRAM_TESTER_LFSR_EN
    logic [15:0]           lfsr_r;
    logic [DATA_BITS+15:0] seed_ext_s;
    logic [15:0]           seed_lfsr_s;
    logic [DATA_BITS-1:0]  value_s;

    // Narrow or widen the seed to 16 bits and keep the LFSR out of the all-zero lockup
    always_comb begin
        seed_ext_s = {16'd0, seed};
        if (seed_ext_s[15:0] == 16'd0) begin
            seed_lfsr_s = 16'h0001;
        end else begin
            seed_lfsr_s = seed_ext_s[15:0];
        end
    end

    // LFSR state: load has priority over step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'd0;
        end else if (load) begin
            lfsr_r <= seed_lfsr_s;
        end else if (step) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    // Replicate the 16-bit state across the data word
    always_comb begin
        value_s = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            value_s[i] = lfsr_r[i % 16];
        end
    end

    assign value = value_s;
`else
    logic [DATA_BITS-1:0] count_r;

    // Incrementing counter: load has priority over step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= seed;
        end else if (step) begin
            count_r <= count_r + DATA_BITS'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign value = count_r;
`endif

endmodule

// File: rtl/sdram_burst_tester.sv
// Self-checking SDRAM burst traffic generator. Writes NUM_BURSTS bursts of a
// seeded pattern from base_addr, reads them back, and reports pass/fail, an
// error count and the last word read. Optional macro: SDRAM_TESTER_LFSR_EN
// selects an LFSR pattern instead of the incrementing one.
module sdram_burst_tester
    import sdram_tester_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int BURST_BITS = DEF_BURST_BITS,
    parameter int BURST_LEN  = 128,
    parameter int NUM_BURSTS = 4
) (
    input  logic                  sdram_clk_ref,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_BITS-1:0]  seed,
    input  logic [ADDR_BITS-1:0]  base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [DATA_BITS-1:0]  last_rd_data,
    output logic                  wr_burst_req,
    output logic [ADDR_BITS-1:0]  wr_burst_addr,
    output logic [BURST_BITS-1:0] wr_burst_len,
    output logic [DATA_BITS-1:0]  wr_burst_data,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish,
    output logic                  rd_burst_req,
    output logic [ADDR_BITS-1:0]  rd_burst_addr,
    output logic [BURST_BITS-1:0] rd_burst_len,
    input  logic [DATA_BITS-1:0]  rd_burst_data,
    input  logic                  rd_burst_data_valid,
    input  logic                  rd_burst_finish
);

    localparam int BIDX_BITS = $clog2(NUM_BURSTS + 1);
    // One spare bit so an over-long burst cannot alias back onto BURST_LEN
    localparam int WIDX_BITS = BURST_BITS + 1;

    localparam logic [ADDR_BITS-1:0]  BURST_STRIDE = ADDR_BITS'(BURST_LEN);
    localparam logic [BURST_BITS-1:0] BURST_LEN_W  = BURST_BITS'(BURST_LEN);
    localparam logic [WIDX_BITS-1:0]  WORD_TARGET  = WIDX_BITS'(BURST_LEN);
    localparam logic [WIDX_BITS-1:0]  WORD_MAX     = {WIDX_BITS{1'b1}};
    localparam logic [BIDX_BITS-1:0]  BURST_LAST   = BIDX_BITS'(NUM_BURSTS - 1);

    tester_state_t         state_r;
    logic [DATA_BITS-1:0]  seed_r;
    logic [ADDR_BITS-1:0]  base_r;
    logic [ADDR_BITS-1:0]  off_r;
    logic [BIDX_BITS-1:0]  burst_idx_r;
    logic [WIDX_BITS-1:0]  word_idx_r;
    logic [15:0]           err_count_r;
    logic                  pass_r;
    logic                  done_r;
    logic                  busy_r;
    logic [DATA_BITS-1:0]  last_rd_data_r;
    logic                  wr_req_r;
    logic [ADDR_BITS-1:0]  wr_addr_r;
    logic [BURST_BITS-1:0] wr_len_r;
    logic                  rd_req_r;
    logic [ADDR_BITS-1:0]  rd_addr_r;
    logic [BURST_BITS-1:0] rd_len_r;

    logic                  gen_load_s;
    logic [DATA_BITS-1:0]  gen_seed_s;
    logic                  wr_step_s;
    logic                  rd_valid_s;
    logic                  rd_fin_s;
    logic                  mismatch_s;
    logic                  len_err_s;
    logic [WIDX_BITS-1:0]  word_cnt_s;
    logic [1:0]            err_inc_s;
    logic [16:0]           err_sum_s;
    logic [15:0]           err_next_s;
    logic [DATA_BITS-1:0]  wr_value_s;
    logic [DATA_BITS-1:0]  rd_value_s;

    // Write-data generator
    sdram_pattern_gen #(.DATA_BITS(DATA_BITS)) u_wr_gen (
        .clk   (sdram_clk_ref),
        .rst_n (rst_n),
        .load  (gen_load_s),
        .seed  (gen_seed_s),
        .step  (wr_step_s),
        .value (wr_value_s)
    );

    // Read-data predictor, same sequence as the writer
    sdram_pattern_gen #(.DATA_BITS(DATA_BITS)) u_rd_chk (
        .clk   (sdram_clk_ref),
        .rst_n (rst_n),
        .load  (gen_load_s),
        .seed  (gen_seed_s),
        .step  (rd_valid_s),
        .value (rd_value_s)
    );

    // Generator control and read-side checking arithmetic
    always_comb begin
        gen_load_s = 1'b0;
        gen_seed_s = seed_r;
        case (state_r)
            ST_IDLE: begin
                gen_load_s = start;
                gen_seed_s = seed;
            end
            ST_WR_WAIT: begin
                gen_load_s = wr_burst_finish && (burst_idx_r == BURST_LAST);
            end
            default: begin
                gen_load_s = 1'b0;
            end
        endcase

        wr_step_s  = wr_burst_data_req && ((state_r == ST_WR_REQ) || (state_r == ST_WR_WAIT));
        rd_valid_s = rd_burst_data_valid && (state_r == ST_RD_WAIT);
        rd_fin_s   = rd_burst_finish && (state_r == ST_RD_WAIT);
        mismatch_s = rd_valid_s && (rd_burst_data != rd_value_s);

        if (rd_valid_s && (word_idx_r != WORD_MAX)) begin
            word_cnt_s = word_idx_r + WIDX_BITS'(1);
        end else begin
            word_cnt_s = word_idx_r;
        end

        // The word arriving with finish is counted before the length check
        len_err_s  = rd_fin_s && (word_cnt_s != WORD_TARGET);
        err_inc_s  = {1'b0, mismatch_s} + {1'b0, len_err_s};
        err_sum_s  = {1'b0, err_count_r} + {15'd0, err_inc_s};
        if (err_sum_s[16]) begin
            err_next_s = 16'hFFFF;
        end else begin
            err_next_s = err_sum_s[15:0];
        end
    end

    // Tester FSM with registered outputs
    always_ff @(posedge sdram_clk_ref or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            seed_r         <= '0;
            base_r         <= '0;
            off_r          <= '0;
            burst_idx_r    <= '0;
            word_idx_r     <= '0;
            err_count_r    <= 16'd0;
            pass_r         <= 1'b0;
            done_r         <= 1'b0;
            busy_r         <= 1'b0;
            last_rd_data_r <= '0;
            wr_req_r       <= 1'b0;
            wr_addr_r      <= '0;
            wr_len_r       <= '0;
            rd_req_r       <= 1'b0;
            rd_addr_r      <= '0;
            rd_len_r       <= '0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        seed_r      <= seed;
                        base_r      <= base_addr;
                        off_r       <= '0;
                        burst_idx_r <= '0;
                        word_idx_r  <= '0;
                        err_count_r <= 16'd0;
                        busy_r      <= 1'b1;
                        wr_len_r    <= BURST_LEN_W;
                        rd_len_r    <= BURST_LEN_W;
                        state_r     <= ST_WR_REQ;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    wr_req_r  <= 1'b1;
                    wr_addr_r <= base_r + off_r;
                    state_r   <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (wr_burst_finish) begin
                        wr_req_r <= 1'b0;
                        if (burst_idx_r == BURST_LAST) begin
                            burst_idx_r <= '0;
                            off_r       <= '0;
                            state_r     <= ST_RD_REQ;
                        end else begin
                            burst_idx_r <= burst_idx_r + BIDX_BITS'(1);
                            off_r       <= off_r + BURST_STRIDE;
                            state_r     <= ST_WR_REQ;
                        end
                    end else begin
                        state_r <= ST_WR_WAIT;
                    end
                end
                ST_RD_REQ: begin
                    rd_req_r  <= 1'b1;
                    rd_addr_r <= base_r + off_r;
                    state_r   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    err_count_r <= err_next_s;
                    if (rd_burst_data_valid) begin
                        last_rd_data_r <= rd_burst_data;
                    end else begin
                        last_rd_data_r <= last_rd_data_r;
                    end
                    if (rd_burst_data_valid || rd_burst_finish) begin
                        rd_req_r <= 1'b0;
                    end else begin
                        rd_req_r <= rd_req_r;
                    end
                    if (rd_burst_finish) begin
                        word_idx_r <= '0;
                        if (burst_idx_r == BURST_LAST) begin
                            burst_idx_r <= '0;
                            state_r     <= ST_FINISH;
                        end else begin
                            burst_idx_r <= burst_idx_r + BIDX_BITS'(1);
                            off_r       <= off_r + BURST_STRIDE;
                            state_r     <= ST_RD_REQ;
                        end
                    end else begin
                        word_idx_r <= word_cnt_s;
                        state_r    <= ST_RD_WAIT;
                    end
                end
                ST_FINISH: begin
                    pass_r  <= (err_count_r == 16'd0);
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    wr_req_r <= 1'b0;
                    rd_req_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign err_count     = err_count_r;
    assign last_rd_data  = last_rd_data_r;
    assign wr_burst_req  = wr_req_r;
    assign wr_burst_addr = wr_addr_r;
    assign wr_burst_len  = wr_len_r;
    assign wr_burst_data = wr_value_s;
    assign rd_burst_req  = rd_req_r;
    assign rd_burst_addr = rd_addr_r;
    assign rd_burst_len  = rd_len_r;

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Directed bench for sdram_burst_tester: the initial block plays the role of
// an ideal SDRAM core (64-word memory indexed by the low address bits) with
// BURST_LEN=8, NUM_BURSTS=2.
module tb_sdram_burst_tester;

    localparam int TMO = 200;

    logic        sdram_clk_ref = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] seed = 16'd0;
    logic [23:0] base_addr = 24'd0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] last_rd_data;
    logic        wr_burst_req;
    logic [23:0] wr_burst_addr;
    logic [9:0]  wr_burst_len;
    logic [15:0] wr_burst_data;
    logic        wr_burst_data_req = 1'b0;
    logic        wr_burst_finish = 1'b0;
    logic        rd_burst_req;
    logic [23:0] rd_burst_addr;
    logic [9:0]  rd_burst_len;
    logic [15:0] rd_burst_data = 16'd0;
    logic        rd_burst_data_valid = 1'b0;
    logic        rd_burst_finish = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [15:0] mem [0:63];

    sdram_burst_tester #(
        .DATA_BITS(16), .ADDR_BITS(24), .BURST_BITS(10),
        .BURST_LEN(8), .NUM_BURSTS(2)
    ) dut (
        .sdram_clk_ref       (sdram_clk_ref),
        .rst_n               (rst_n),
        .start               (start),
        .seed                (seed),
        .base_addr           (base_addr),
        .busy                (busy),
        .done                (done),
        .pass                (pass),
        .err_count           (err_count),
        .last_rd_data        (last_rd_data),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_finish     (rd_burst_finish)
    );

    always #5 sdram_clk_ref = ~sdram_clk_ref;

    // Word n of a pass started with seed s
    function automatic logic [15:0] exp_word(input logic [15:0] s, input int n);
`ifdef SDRAM_TESTER_LFSR_EN
        logic [15:0] v;
        v = (s == 16'd0) ? 16'h0001 : s;
        for (int k = 0; k < n; k++) begin
            v = v[0] ? ({1'b0, v[15:1]} ^ 16'hB400) : {1'b0, v[15:1]};
        end
        return v;
`else
        return s + n[15:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, pass}, 32'd0);
        chk({tag, "_err"}, {16'd0, err_count}, 32'd0);
        chk({tag, "_last"}, {16'd0, last_rd_data}, 32'd0);
        chk({tag, "_wrreq"}, {31'd0, wr_burst_req}, 32'd0);
        chk({tag, "_wraddr"}, {8'd0, wr_burst_addr}, 32'd0);
        chk({tag, "_wrlen"}, {22'd0, wr_burst_len}, 32'd0);
        chk({tag, "_wrdata"}, {16'd0, wr_burst_data}, 32'd0);
        chk({tag, "_rdreq"}, {31'd0, rd_burst_req}, 32'd0);
        chk({tag, "_rdaddr"}, {8'd0, rd_burst_addr}, 32'd0);
        chk({tag, "_rdlen"}, {22'd0, rd_burst_len}, 32'd0);
    endtask

    task automatic do_start(input logic [15:0] s, input logic [23:0] b);
        @(negedge sdram_clk_ref);
        seed = s;
        base_addr = b;
        start = 1'b1;
        @(negedge sdram_clk_ref);
        start = 1'b0;
        seed = 16'hDEAD;
        base_addr = 24'h0ABCDE;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_req(input bit is_wr);
        int t;
        t = 0;
        @(negedge sdram_clk_ref);
        while (((is_wr ? wr_burst_req : rd_burst_req) !== 1'b1) && (t < TMO)) begin
            @(negedge sdram_clk_ref);
            t++;
        end
        chk(is_wr ? "wr_req_seen" : "rd_req_seen", {31'd0, (is_wr ? wr_burst_req : rd_burst_req)}, 32'd1);
    endtask

    // Act as the core for one write burst; optionally pulse start at word start_at
    task automatic write_burst(input logic [15:0] s, input int bidx, input logic [23:0] exp_addr,
                               input int start_at);
        int a;
        wait_req(1'b1);
        chk("wr_addr", {8'd0, wr_burst_addr}, {8'd0, exp_addr});
        chk("wr_len", {22'd0, wr_burst_len}, 32'd8);
        a = int'(wr_burst_addr);
        for (int i = 0; i < 8; i++) begin
            mem[(a + i) % 64] = wr_burst_data;
            chk("wr_data", {16'd0, wr_burst_data}, {16'd0, exp_word(s, bidx * 8 + i)});
            wr_burst_data_req = 1'b1;
            if (i == start_at) begin
                start = 1'b1;
                seed = 16'h5555;
                base_addr = 24'h000030;
            end else begin
                start = 1'b0;
            end
            @(negedge sdram_clk_ref);
        end
        start = 1'b0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish = 1'b1;
        @(negedge sdram_clk_ref);
        wr_burst_finish = 1'b0;
    endtask

    // Act as the core for one read burst of nwords words
    task automatic read_burst(input logic [23:0] exp_addr, input int nwords, input int flip_idx,
                              input bit fin_with_last);
        int a;
        wait_req(1'b0);
        chk("rd_addr", {8'd0, rd_burst_addr}, {8'd0, exp_addr});
        chk("rd_len", {22'd0, rd_burst_len}, 32'd8);
        a = int'(rd_burst_addr);
        for (int i = 0; i < nwords; i++) begin
            if (i == 1) begin
                chk("rd_req_drop", {31'd0, rd_burst_req}, 32'd0);
            end
            rd_burst_data_valid = 1'b1;
            rd_burst_data = mem[(a + i) % 64] ^ ((i == flip_idx) ? 16'h0001 : 16'h0000);
            rd_burst_finish = fin_with_last && (i == nwords - 1);
            @(negedge sdram_clk_ref);
        end
        rd_burst_data_valid = 1'b0;
        if (!fin_with_last) begin
            rd_burst_finish = 1'b1;
            @(negedge sdram_clk_ref);
        end
        rd_burst_finish = 1'b0;
    endtask

    task automatic wait_done(input string tag, input bit exp_pass, input logic [15:0] exp_err,
                             input logic [15:0] exp_last);
        int t;
        t = 0;
        while ((done !== 1'b1) && (t < TMO)) begin
            @(negedge sdram_clk_ref);
            t++;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
        chk({tag, "_err"}, {16'd0, err_count}, {16'd0, exp_err});
        chk({tag, "_last"}, {16'd0, last_rd_data}, {16'd0, exp_last});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge sdram_clk_ref);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic full_pass(input string tag, input logic [15:0] s, input logic [23:0] b);
        do_start(s, b);
        write_burst(s, 0, b, -1);
        write_burst(s, 1, b + 24'd8, -1);
        read_burst(b, 8, -1, 1'b0);
        read_burst(b + 24'd8, 8, -1, 1'b1);
        wait_done(tag, 1'b1, 16'd0, exp_word(s, 15));
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'd0;

        // Reset state
        repeat (3) @(negedge sdram_clk_ref);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Clean pass, seed 0x0010 at base 0: last word 0x001F
        full_pass("clean", 16'h0010, 24'd0);
`ifndef SDRAM_TESTER_LFSR_EN
        chk("clean_mem0", {16'd0, mem[0]}, 32'h0010);
        chk("clean_mem15", {16'd0, mem[15]}, 32'h001F);
`endif

        // Single-bit corruption of word 5, address wrap across 2^24
        do_start(16'h1234, 24'hFFFFF8);
        write_burst(16'h1234, 0, 24'hFFFFF8, -1);
        write_burst(16'h1234, 1, 24'h000000, -1);
        read_burst(24'hFFFFF8, 8, 5, 1'b0);
        read_burst(24'h000000, 8, -1, 1'b0);
        wait_done("flip", 1'b0, 16'd1, exp_word(16'h1234, 15));

        // Short final burst (7 words, all correct), data wrapping through 0xFFFF
        do_start(16'hFFF8, 24'h000010);
        write_burst(16'hFFF8, 0, 24'h000010, -1);
        write_burst(16'hFFF8, 1, 24'h000018, -1);
        read_burst(24'h000010, 8, -1, 1'b1);
        read_burst(24'h000018, 7, -1, 1'b0);
        wait_done("short", 1'b0, 16'd1, exp_word(16'hFFF8, 14));

        // start during WR_WAIT is ignored; exactly two bursts each way
        do_start(16'h0010, 24'd0);
        write_burst(16'h0010, 0, 24'd0, 3);
        write_burst(16'h0010, 1, 24'd8, -1);
        read_burst(24'd0, 8, -1, 1'b0);
        read_burst(24'd8, 8, -1, 1'b0);
        wait_done("ignore", 1'b1, 16'd0, exp_word(16'h0010, 15));
        begin
            int extra;
            extra = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge sdram_clk_ref);
                if ((wr_burst_req === 1'b1) || (rd_burst_req === 1'b1) || (busy === 1'b1)) extra++;
            end
            chk("ignore_no_extra", extra, 32'd0);
        end

        // Asynchronous reset in RD_WAIT, then a clean pass
        do_start(16'h0100, 24'd0);
        write_burst(16'h0100, 0, 24'd0, -1);
        write_burst(16'h0100, 1, 24'd8, -1);
        wait_req(1'b0);
        for (int i = 0; i < 3; i++) begin
            rd_burst_data_valid = 1'b1;
            rd_burst_data = mem[i];
            @(negedge sdram_clk_ref);
        end
        rd_burst_data_valid = 1'b0;
        chk("pre_rst_last", {16'd0, last_rd_data}, {16'd0, exp_word(16'h0100, 2)});
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("midrst");
        @(negedge sdram_clk_ref);
        rst_n = 1'b1;
        full_pass("after_rst", 16'h0100, 24'd0);

`ifdef SDRAM_TESTER_LFSR_EN
        // Zero seed promoted to 1; second word is its LFSR successor
        full_pass("lfsr", 16'h0000, 24'd0);
        chk("lfsr_w0", {16'd0, mem[0]}, 32'h0001);
        chk("lfsr_w1", {16'd0, mem[1]}, 32'hB400);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
